// File: rtl/seg595_rx.sv
// rtl/seg595_rx.sv - 74HC595 bus snooper: captures 16-bit segment/select frames into an 8-digit store.
// Optional symbol decode and code storage built when SEG595_DECODE_EN is defined.
module seg595_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_in,
   input  logic       rclk_in,
   input  logic       sdio_in,
   output logic       frame_valid,
   output logic [2:0] frame_digit,
   output logic [7:0] frame_seg,
   output logic [4:0] frame_code,
   output logic       frame_err,
   input  logic [2:0] rd_idx,
   output logic [7:0] rd_seg,
   output logic [4:0] rd_code
);

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] rclk_sync_q, rclk_sync_d;
   logic [SYNC_STAGES-1:0] sdio_sync_q, sdio_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   rclk_prev_q, rclk_prev_d;
   logic [15:0]            shift_q, shift_d;
   logic [4:0]             cnt_q, cnt_d;
   logic                   valid_pend_q, valid_pend_d;
   logic                   err_pend_q, err_pend_d;
   logic                   frame_valid_q, frame_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [2:0]             digit_q, digit_d;
   logic [7:0]             seg_q, seg_d;
   logic [7:0]             seg_mem_q [8];
   logic [7:0]             seg_mem_d [8];

   logic       sclk_rise, rclk_rise, sdio_s, one_zero, good;
   logic [7:0] sel_n;
   logic [2:0] sel_idx;

`ifdef SEG595_DECODE_EN
   logic [4:0] code_q, code_d;
   logic [4:0] code_mem_q [8];
   logic [4:0] code_mem_d [8];

   // dp is not part of the symbol, so it is forced off before matching
   function automatic logic [4:0] decode(input logic [7:0] seg);
      case (seg | 8'h80)
         8'hC0:   decode = 5'd0;
         8'hF9:   decode = 5'd1;
         8'hA4:   decode = 5'd2;
         8'hB0:   decode = 5'd3;
         8'h99:   decode = 5'd4;
         8'h92:   decode = 5'd5;
         8'h82:   decode = 5'd6;
         8'hF8:   decode = 5'd7;
         8'h80:   decode = 5'd8;
         8'h90:   decode = 5'd9;
         8'hBF:   decode = 5'd12;
         8'h86:   decode = 5'd15;
         8'hFF:   decode = 5'd16;
         8'hAF:   decode = 5'd17;
         8'hB7:   decode = 5'd18;
         default: decode = 5'd31;
      endcase
   endfunction
`endif

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      rclk_sync_d = {rclk_sync_q[SYNC_STAGES-2:0], rclk_in};
      sdio_sync_d = {sdio_sync_q[SYNC_STAGES-2:0], sdio_in};
      sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
      rclk_prev_d = rclk_sync_q[SYNC_STAGES-1];
      sclk_rise   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      rclk_rise   = rclk_sync_q[SYNC_STAGES-1] & ~rclk_prev_q;
      sdio_s      = sdio_sync_q[SYNC_STAGES-1];

      sel_n    = ~shift_q[7:0];
      one_zero = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
      sel_idx  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (sel_n[i]) sel_idx = 3'(i);
      end
      // latch sees the pre-shift register when both edges land together
      good = rclk_rise && (cnt_q == 5'd16) && one_zero;

      shift_d = sclk_rise ? {shift_q[14:0], sdio_s} : shift_q;
      if (rclk_rise)                          cnt_d = sclk_rise ? 5'd1 : 5'd0;
      else if (sclk_rise && cnt_q != 5'd17)   cnt_d = cnt_q + 5'd1;
      else                                    cnt_d = cnt_q;

      valid_pend_d  = good;
      err_pend_d    = rclk_rise && !good;
      frame_valid_d = valid_pend_q;
      frame_err_d   = err_pend_q;

      digit_d   = digit_q;
      seg_d     = seg_q;
      seg_mem_d = seg_mem_q;
      if (good) begin
         digit_d            = sel_idx;
         seg_d              = shift_q[15:8];
         seg_mem_d[sel_idx] = shift_q[15:8];
      end
`ifdef SEG595_DECODE_EN
      code_d     = code_q;
      code_mem_d = code_mem_q;
      if (good) begin
         code_d              = decode(shift_q[15:8]);
         code_mem_d[sel_idx] = decode(shift_q[15:8]);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q   <= '0;
         rclk_sync_q   <= '0;
         sdio_sync_q   <= '0;
         sclk_prev_q   <= 1'b0;
         rclk_prev_q   <= 1'b0;
         shift_q       <= 16'd0;
         cnt_q         <= 5'd0;
         valid_pend_q  <= 1'b0;
         err_pend_q    <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         digit_q       <= 3'd0;
         seg_q         <= 8'hFF;
         for (int i = 0; i < 8; i++) seg_mem_q[i] <= 8'hFF;
`ifdef SEG595_DECODE_EN
         code_q <= 5'd16;
         for (int i = 0; i < 8; i++) code_mem_q[i] <= 5'd16;
`endif
      end else begin
         sclk_sync_q   <= sclk_sync_d;
         rclk_sync_q   <= rclk_sync_d;
         sdio_sync_q   <= sdio_sync_d;
         sclk_prev_q   <= sclk_prev_d;
         rclk_prev_q   <= rclk_prev_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         valid_pend_q  <= valid_pend_d;
         err_pend_q    <= err_pend_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         digit_q       <= digit_d;
         seg_q         <= seg_d;
         seg_mem_q     <= seg_mem_d;
`ifdef SEG595_DECODE_EN
         code_q     <= code_d;
         code_mem_q <= code_mem_d;
`endif
      end
   end

   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign frame_digit = digit_q;
   assign frame_seg   = seg_q;
   assign rd_seg      = seg_mem_q[rd_idx];
`ifdef SEG595_DECODE_EN
   assign frame_code  = code_q;
   assign rd_code     = code_mem_q[rd_idx];
`else
   assign frame_code  = 5'd31;
   assign rd_code     = 5'd31;
`endif

endmodule

// File: doc/seg595_rx.md
SEG595_RX -- requirements
Module: seg595_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of input synchronizer flops on sclk_in, rclk_in and sdio_in; legal range 2..4.
REQ-002 clk  input  1  system clock, 12 MHz nominal.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sclk_in  input  1  74HC595 SCK (shift clock), asynchronous to clk.
REQ-005 rclk_in  input  1  74HC595 RCK (storage/latch clock), asynchronous to clk.
REQ-006 sdio_in  input  1  74HC595 SER (serial data), asynchronous to clk.
REQ-007 frame_valid  output  1  one-cycle pulse when a good frame is stored.
REQ-008 frame_digit  output  3  index of the digit written by the last good frame.
REQ-009 frame_seg  output  8  raw segment byte of the last good frame.
REQ-010 frame_code  output  5  decoded symbol code of the last good frame.
REQ-011 frame_err  output  1  one-cycle pulse when a latch event is rejected.
REQ-012 rd_idx  input  3  digit readout index.
REQ-013 rd_seg  output  8  stored segment byte for digit rd_idx.
REQ-014 rd_code  output  5  stored symbol code for digit rd_idx.

Function
REQ-015 Frame format: exactly 16 bits, MSB first. The first 8 bits are the segment byte {dp,g,f,e,d,c,b,a}, active-low. The last 8 bits are the digit select, active-low one-hot; bit k low selects digit k.
REQ-016 Each input passes through SYNC_STAGES flops; one further flop provides edge detection, sampled on rising clk.
REQ-017 A synchronized sclk rising edge shifts the synchronized sdio into a 16-bit shift register (LSB in) and increments a 5-bit bit counter, which saturates at 17.
REQ-018 A synchronized rclk rising edge is a latch event; the frame is good iff bit count == 16 and the select byte has exactly one zero bit.
REQ-019 On a good latch: write the segment byte and its code into entry k of the 8-entry store; update frame_digit, frame_seg and frame_code; pulse frame_valid the following cycle.
REQ-020 On a bad latch: the store and the frame_* outputs are unchanged; pulse frame_err the following cycle.
REQ-021 Every latch event clears the bit counter to 0.
REQ-022 Latency: rclk_in rising to frame_valid/frame_err high = SYNC_STAGES+2 clk cycles.
REQ-023 sclk and rclk rising detected in the same cycle: the latch evaluates the pre-shift register and count; the shifted bit then becomes bit 1 of the next frame (counter = 1).
REQ-024 Decode ignores dp (bit7 forced to 1). Patterns map as follows; any other pattern maps to 31.
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9
  - BF(-)→12, 86(E)→15, FF(blank)→16, AF(r)→17, B7(=)→18
REQ-025 rd_seg and rd_code are combinational reads of the store.
REQ-026 Fewer or more than 16 shifts before a latch always produces frame_err, never a partial write.

Reset
REQ-027 Assertion immediately clears the synchronizers, edge flops, shift register and bit counter.
REQ-028 Reset values:
  - frame_valid = 0, frame_err = 0
  - frame_digit = 0, frame_seg = 8'hFF, frame_code = 16
  - every store entry = seg 8'hFF, code 16
REQ-029 A frame in progress when reset asserts is discarded; the first frame after deassertion must contain a full 16 shifts.

Configuration
REQ-030 Macro SEG595_DECODE_EN.
  - Defined: the REQ-024 decode is built; frame_code and rd_code carry decoded codes.
  - Undefined: the decode logic and code storage are omitted; frame_code and rd_code are tied to 5'd31. All other behaviour is identical.

Verification
REQ-031 Shift 0x92 then 0xFE, then pulse rclk → frame_valid after SYNC_STAGES+2 cycles; frame_digit=0, frame_seg=0x92, code=5; rd_idx=0 returns 0x92/5.
REQ-032 Load frames {0xC0,0x7F}, {0x12,0xFB}, then rd_idx=7 → 0xC0/0; rd_idx=2 → 0x12/5 (dp ignored); other entries FF/16.
REQ-033 Shift 15 bits then rclk → frame_err pulse, store unchanged. Then shift 17 bits then rclk → frame_err. Then a good 16-bit frame → frame_valid.
REQ-034 Select 0xFC (two digits low) with count 16 → frame_err, no write. Segment 0x88 on digit 3 → code 31 with the macro defined, 31 with it undefined.
REQ-035 Assert rst_n low after 8 shifts, release it, then send a full good frame for digit 4 → only entry 4 updated; no frame_err from the aborted frame.
REQ-036 sclk and rclk rising in the same cycle as the 17th edge after 16 good shifts → good latch of the first 16 bits, then counter = 1.
